// File: rtl/imem_loader_pkg.sv
// Shared types, widths and helpers for the i_memory program loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_W      = 9;
    localparam int unsigned LEN_MAX    = 256;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 2 * BYTE_W;
    localparam int unsigned BASE_DEF   = 0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_HI   = 3'd1,
        S_RX_LO   = 3'd2,
        S_WRITE   = 3'd3,
        S_RELEASE = 3'd4,
        S_START   = 3'd5,
        S_RUN     = 3'd6
    } state_e;

    // Word count actually loaded: requests above the memory depth saturate.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > LEN_W'(LEN_MAX)) ? LEN_W'(LEN_MAX) : l;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, i_memory write port out.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_data, mem_we
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_addr, mem_data, mem_we
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects two accepted bytes (high first) into one instruction word.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                take,
    input  logic [BYTE_W-1:0]   byte_in,
    output logic [2*BYTE_W-1:0] word,
    output logic                word_ok_c
);

    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic              phase_q, phase_d;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        phase_d = phase_q;
        if (clear) begin
            phase_d = 1'b0;
        end else if (take) begin
            if (!phase_q) begin
                hi_d    = byte_in;
                phase_d = 1'b1;
            end else begin
                lo_d    = byte_in;
                phase_d = 1'b0;
            end
        end
    end

    // Asserted in the cycle the low byte is taken, completing a word.
    assign word_ok_c = take & phase_q & ~clear;
    assign word      = {hi_q, lo_q};

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q    <= '0;
            lo_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into i_memory, holding pcpu in reset until the load completes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned BASE   = BASE_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_req,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    imem_loader_if.slave     bus,
    output logic             cpu_reset_n,
    output logic             cpu_enable,
    output logic             cpu_start,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic byte_ready_q, byte_ready_d;
    logic mem_we_q, mem_we_d;
    logic cpu_reset_n_q, cpu_reset_n_d;
    logic cpu_enable_q, cpu_enable_d;
    logic cpu_start_q, cpu_start_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;

    logic                take_c;
    logic                word_ok_c;
    logic [2*BYTE_W-1:0] word;

    assign take_c = byte_ready_q & bus.byte_valid & ~abort;

    imem_loader_byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (abort),
        .take      (take_c),
        .byte_in   (bus.byte_in),
        .word      (word),
        .word_ok_c (word_ok_c)
    );

    // Next state, counters, and outputs decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (load_req) begin
                    if (len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_RX_HI;
                        cnt_d   = clamp_len(len);
                        addr_d  = ADDR_W'(BASE);
                    end
                end
            end
            S_RX_HI:   if (take_c)    state_d = S_RX_LO;
            S_RX_LO:   if (word_ok_c) state_d = S_WRITE;
            S_WRITE: begin
                cnt_d   = cnt_q - LEN_W'(1);
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? S_RELEASE : S_RX_HI;
            end
            S_RELEASE: state_d = S_START;
            S_START:   state_d = S_RUN;
            default:   state_d = S_IDLE;
        endcase

        // Abort overrides any load request or progress made this cycle.
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q;
            addr_d  = addr_q;
            err_d   = 1'b0;
        end

        byte_ready_d  = (state_d == S_RX_HI) || (state_d == S_RX_LO);
        mem_we_d      = (state_d == S_WRITE);
        cpu_reset_n_d = (state_d == S_RELEASE) || (state_d == S_START) || (state_d == S_RUN);
        cpu_enable_d  = (state_d == S_START) || (state_d == S_RUN);
        cpu_start_d   = (state_d == S_START);
        busy_d        = (state_d == S_RX_HI) || (state_d == S_RX_LO) || (state_d == S_WRITE) ||
                        (state_d == S_RELEASE) || (state_d == S_START);
        done_d        = (state_d == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            addr_q        <= ADDR_W'(BASE);
            byte_ready_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            cpu_enable_q  <= 1'b0;
            cpu_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            byte_ready_q  <= byte_ready_d;
            mem_we_q      <= mem_we_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            cpu_enable_q  <= cpu_enable_d;
            cpu_start_q   <= cpu_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_data   = DATA_W'(word);
    assign cpu_reset_n    = cpu_reset_n_q;
    assign cpu_enable     = cpu_enable_q;
    assign cpu_start      = cpu_start_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a transaction-level model checked every cycle.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_req;
    logic       abort;
    logic [8:0] len;
    logic       cpu_reset_n, cpu_enable, cpu_start, busy, done, err;

    imem_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    imem_loader #(.ADDR_W(8), .DATA_W(16), .BASE(0)) dut (
        .clock       (clock),
        .reset       (reset),
        .load_req    (load_req),
        .abort       (abort),
        .len         (len),
        .bus         (bus.slave),
        .cpu_reset_n (cpu_reset_n),
        .cpu_enable  (cpu_enable),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: loader mode, words left, next address, byte pairing; outputs due next cycle.
    typedef enum int {M_IDLE, M_LOAD, M_FIN, M_RUN} mode_t;
    mode_t       m_mode = M_IDLE;
    mode_t       mode_now;
    int          m_words = 0;
    int          m_cd = 0;
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_hi = 8'h00;
    logic [15:0] m_word = 16'h0000;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic        m_phase = 1'b0;
    logic        ready_now;
    logic        primed = 1'b0;

    logic [15:0] shadow [256];
    int          we_count = 0;
    int          err_count = 0;
    int          start_count = 0;

    always @(negedge clock) begin
        if (primed) begin
            chk("byte_ready", 32'(bus.byte_ready), 32'(m_mode == M_LOAD && !m_we));
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            if (m_we) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
                chk("mem_data", 32'(bus.mem_data), 32'(m_word));
            end
            chk("cpu_reset_n", 32'(cpu_reset_n), 32'(m_mode == M_FIN || m_mode == M_RUN));
            chk("cpu_enable", 32'(cpu_enable), 32'((m_mode == M_FIN && m_cd == 0) || m_mode == M_RUN));
            chk("cpu_start", 32'(cpu_start), 32'(m_mode == M_FIN && m_cd == 0));
            chk("busy", 32'(busy), 32'(m_mode == M_LOAD || m_mode == M_FIN));
            chk("done", 32'(done), 32'(m_mode == M_RUN));
            chk("err", 32'(err), 32'(m_err));
            if (bus.mem_we === 1'b1) begin
                shadow[bus.mem_addr] = bus.mem_data;
                we_count++;
            end
            if (err === 1'b1) err_count++;
            if (cpu_start === 1'b1) start_count++;
        end

        mode_now  = m_mode;
        ready_now = (m_mode == M_LOAD) && !m_we;
        // Release then start follow the last write on consecutive cycles.
        if (m_mode == M_FIN) begin
            if (m_cd == 0) m_mode = M_RUN;
            else m_cd--;
        end
        if (m_we) begin
            m_words--;
            m_addr = m_addr + 8'd1;
            if (m_words == 0) begin
                m_mode = M_FIN;
                m_cd   = 1;
            end
        end
        m_we  = 1'b0;
        m_err = 1'b0;

        if (reset === 1'b1) begin
            m_mode  = M_IDLE;
            m_phase = 1'b0;
            primed  = 1'b1;
        end else if (abort) begin
            m_mode  = M_IDLE;
            m_phase = 1'b0;
        end else if ((mode_now == M_IDLE || mode_now == M_RUN) && load_req) begin
            if (len == 9'd0) begin
                m_err = 1'b1;
            end else begin
                m_mode  = M_LOAD;
                m_words = (len > 9'd256) ? 256 : int'(len);
                m_addr  = 8'h00;
                m_phase = 1'b0;
            end
        end else if (mode_now == M_LOAD && ready_now && bus.byte_valid) begin
            if (!m_phase) begin
                m_hi    = bus.byte_in;
                m_phase = 1'b1;
            end else begin
                m_word  = {m_hi, bus.byte_in};
                m_we    = 1'b1;
                m_phase = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_load(input logic [8:0] l);
        load_req = 1'b1;
        len      = l;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit got;
        got = 1'b0;
        repeat (gap) tick();
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clock);
            if (bus.byte_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("send_accepted", 32'(got), 32'd1);
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit got;
        got = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_reached", 32'(got), 32'd1);
        tick();
    endtask

    task automatic chk_reset_vals();
        @(negedge clock);
        chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
        chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("rst_cpu_enable", 32'(cpu_enable), 32'd0);
        chk("rst_cpu_start", 32'(cpu_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wc, ec, sc;
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0000;
        reset          = 1'b1;
        load_req       = 1'b0;
        abort          = 1'b0;
        len            = 9'd0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_reset_vals();

        // 1) two words back-to-back
        wc = we_count; sc = start_count;
        issue_load(9'd2);
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
        wait_done(20);
        chk("t1_word0", 32'(shadow[0]), 32'h1234);
        chk("t1_word1", 32'(shadow[1]), 32'h5678);
        chk("t1_writes", 32'(we_count - wc), 32'd2);
        chk("t1_starts", 32'(start_count - sc), 32'd1);
        chk("t1_addr_after", 32'(bus.mem_addr), 32'h02);

        // 2) same load from RUN with gapped bytes
        shadow[0] = 16'h0000; shadow[1] = 16'h0000;
        wc = we_count;
        issue_load(9'd2);
        send(8'h12, 2); send(8'h34, 2); send(8'h56, 2); send(8'h78, 2);
        wait_done(20);
        chk("t2_word0", 32'(shadow[0]), 32'h1234);
        chk("t2_word1", 32'(shadow[1]), 32'h5678);
        chk("t2_writes", 32'(we_count - wc), 32'd2);

        // 3) len=0 rejected from IDLE
        abort = 1'b1; tick(); abort = 1'b0;
        ec = err_count;
        issue_load(9'd0);
        tick(); tick();
        chk("t3_err_pulses", 32'(err_count - ec), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        chk("t3_cpu_reset_n", 32'(cpu_reset_n), 32'd0);

        // 4) abort mid-word, ignored load_req while loading, then a fresh load
        shadow[0] = 16'h0000; shadow[1] = 16'hDEAD;
        wc = we_count; ec = err_count;
        issue_load(9'd4);
        send(8'h11, 0);
        issue_load(9'd0);
        send(8'h22, 0); send(8'h33, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        tick();
        chk("t4_writes", 32'(we_count - wc), 32'd1);
        chk("t4_no_err", 32'(err_count - ec), 32'd0);
        chk("t4_word0", 32'(shadow[0]), 32'h1122);
        chk("t4_word1_kept", 32'(shadow[1]), 32'hDEAD);
        chk("t4_busy", 32'(busy), 32'd0);
        issue_load(9'd1);
        send(8'hAB, 0); send(8'hCD, 0);
        wait_done(20);
        chk("t4_reload_word0", 32'(shadow[0]), 32'hABCD);

        // 5) len=300 clamps to a full 256-word fill with address wrap
        wc = we_count; sc = start_count;
        issue_load(9'd300);
        for (int i = 0; i < 512; i++) send(8'(i), 0);
        wait_done(20);
        chk("t5_writes", 32'(we_count - wc), 32'd256);
        chk("t5_starts", 32'(start_count - sc), 32'd1);
        chk("t5_word00", 32'(shadow[8'h00]), 32'h0001);
        chk("t5_word10", 32'(shadow[8'h10]), 32'h2021);
        chk("t5_word7f", 32'(shadow[8'h7F]), 32'hFEFF);
        chk("t5_wordff", 32'(shadow[8'hFF]), 32'hFEFF);
        chk("t5_addr_wrap", 32'(bus.mem_addr), 32'h00);

        // 6) reset in RX_LO, then a reload from RUN
        issue_load(9'd2);
        send(8'h5A, 0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk_reset_vals();
        issue_load(9'd1);
        send(8'h01, 0); send(8'h02, 0);
        wait_done(20);
        chk("t6_word0", 32'(shadow[0]), 32'h0102);
        load_req = 1'b1; len = 9'd1;
        tick();
        load_req = 1'b0;
        @(negedge clock);
        chk("t6_reload_rstn", 32'(cpu_reset_n), 32'd0);
        chk("t6_reload_en", 32'(cpu_enable), 32'd0);
        tick();
        send(8'h03, 0); send(8'h04, 0);
        wait_done(20);
        chk("t6_reload_word0", 32'(shadow[0]), 32'h0304);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
